// File: rtl/pcpu_pkg.sv
// Shared pcpu package: register-file FSM states and default sizes.
// Imported by regfile_mp and rf_scoreboard.
package pcpu;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_t;

  localparam int RF_XLEN_DEFAULT  = 32;
  localparam int RF_NREGS_DEFAULT = 32;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for the hazard unit.
// Optional REGFILE_DBG_EN adds the busy_o debug view.
module rf_scoreboard
  import pcpu::*;
#(
  parameter int NREGS = RF_NREGS_DEFAULT,
  parameter int NWR   = 2,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              rsv_en_i,
  input  logic [AW-1:0]     rsv_addr_i,
  input  logic [NWR-1:0]    wr_en_i,
  input  logic [NWR*AW-1:0] wr_addr_i,
  input  logic [NRD*AW-1:0] rd_addr_i,
  output logic [NRD-1:0]    rd_busy_o
`ifdef REGFILE_DBG_EN
  ,
  output logic [NREGS-1:0]  busy_o
`endif
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // next busy: write clears, a reserve in the same cycle wins
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      for (int j = 0; j < NWR; j++) begin
        if (en_i && wr_en_i[j] &&
            wr_addr_i[j*AW +: AW] == AW'(r))
          busy_d[r] = 1'b0;
      end
      if (en_i && rsv_en_i && rsv_addr_i == AW'(r))
        busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // busy vector register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // read ports see the post-edge busy state
  always_comb begin
    rd_busy_o = '0;
    for (int k = 0; k < NRD; k++)
      rd_busy_o[k] = busy_d[rd_addr_i[k*AW +: AW]];
  end

`ifdef REGFILE_DBG_EN
  assign busy_o = busy_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file, synchronous read with write bypass.
// Optional REGFILE_DBG_EN exposes dbg_regs / dbg_busy.
module regfile_mp
  import pcpu::*;
#(
  parameter int XLEN  = RF_XLEN_DEFAULT,
  parameter int NREGS = RF_NREGS_DEFAULT,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr
`ifdef REGFILE_DBG_EN
  ,
  output logic [NREGS*XLEN-1:0] dbg_regs,
  output logic [NREGS-1:0]      dbg_busy
`endif
);

  rf_state_t          state_q;
  logic [AW-1:0]      cnt_q;
  logic               ready_q;
  logic [XLEN-1:0]    mem_q [NREGS];
  logic [NRD*XLEN-1:0] rd_data_q;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]     rd_busy_q;
  logic [NRD-1:0]     sb_busy;
  logic               act;

  assign act = (state_q == RF_READY);

  // init sweep: one entry per cycle, then park in READY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        RF_INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREGS-1)) begin
            state_q <= RF_READY;
            ready_q <= 1'b1;
          end
        end
        RF_READY: ;
        default: ;
      endcase
    end
  end

  // storage: no reset so it can map to LUTRAM
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_INIT) begin
        mem_q[cnt_q] <= '0;
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
            mem_q[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
      end
    end
  end

  // read mux: x0, then newest write, then stored value
  always_comb begin
    rd_data_d = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data_d[k*XLEN +: XLEN] = mem_q[rd_addr[k*AW +: AW]];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] &&
            wr_addr[j*AW +: AW] == rd_addr[k*AW +: AW])
          rd_data_d[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
      end
      if (rd_addr[k*AW +: AW] == '0)
        rd_data_d[k*XLEN +: XLEN] = '0;
    end
  end

  // read registers update only when enabled and ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else if (act) begin
      for (int k = 0; k < NRD; k++) begin
        if (rd_en[k]) begin
          rd_data_q[k*XLEN +: XLEN] <= rd_data_d[k*XLEN +: XLEN];
          rd_busy_q[k] <= sb_busy[k];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR),
    .NRD   (NRD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .en_i       (act),
    .rsv_en_i   (rsv_en),
    .rsv_addr_i (rsv_addr),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .rd_addr_i  (rd_addr),
    .rd_busy_o  (sb_busy)
`ifdef REGFILE_DBG_EN
    ,
    .busy_o     (dbg_busy)
`endif
  );

  assign ready   = ready_q;
  assign rd_data = rd_data_q;
  assign rd_busy = rd_busy_q;

`ifdef REGFILE_DBG_EN
  // flat array view for the register display
  always_comb begin
    dbg_regs = '0;
    for (int r = 1; r < NREGS; r++)
      dbg_regs[r*XLEN +: XLEN] = mem_q[r];
  end
`endif

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read pipeline register file in the ID stage.
- Adds configurable width/depth/port counts, a synchronous read with same-cycle write bypass, and a per-register busy scoreboard for the hazard unit.
- Storage has no asynchronous array reset, so it can infer LUTRAM. A post-reset init FSM clears all entries one per cycle.
- x0 is hard-wired to zero.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 4. Localparam AW = $clog2(NREGS).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports; a higher index has priority.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ready  out  1  high once the init sweep has finished
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*AW  read addresses; port k uses slice k
- rd_data  out  NRD*XLEN  registered read data
- rd_busy  out  NRD  registered busy flag of the addressed register
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- rsv_en  in  1  reserve a destination (set its busy bit)
- rsv_addr  in  AW  register to reserve

Behaviour:
- Reset is clk/rst: asynchronous, active-high.
  - While rst is high: state=INIT, init counter=1, ready=0, rd_data=0, rd_busy=0, all busy bits=0.
  - Array contents are not touched by rst itself.
- FSM INIT:
  - Each posedge writes 0 to entry cnt, then cnt++.
  - The transition to READY happens on the edge that clears entry NREGS-1, so ready rises exactly NREGS-1 posedges after rst falls.
  - In INIT: wr_en and rsv_en are ignored, rd_data and rd_busy hold 0, busy bits stay 0.
- FSM READY: terminal state; leaves only via rst.
- Write, all updates at posedge:
  - Entry wr_addr[j] <= wr_data[j] if wr_en[j] and wr_addr[j]!=0.
  - Same address on several ports: the highest j wins; the others are dropped.
- Read, 1-cycle latency:
  - If rd_en[k] at a posedge, rd_data[k] <= 0 if addr is 0.
  - Else it takes wr_data of the highest-priority enabled write port with a matching address (bypass).
  - Else it takes the stored value.
  - If rd_en[k] is low, rd_data[k] and rd_busy[k] hold.
- Scoreboard, next-state per register r!=0:
  - busy[r] <= 1 if rsv_en and rsv_addr==r.
  - Else busy[r] <= 0 if any write port writes r.
  - Else busy[r] holds.
  - So a reserve and a write to the same r in the same cycle leave busy=1 (new producer wins).
  - rsv_addr=0 is ignored; busy[0] is always 0.
- rd_busy[k] <= next-state busy of the address read by port k, sampled in the same edge as rd_data.
- Reset mid-operation (INIT or READY) aborts immediately and restarts the sweep from 1 after release.

Optional Feature:
- Macro REGFILE_DBG_EN.
- Defined:
  - Extra output port dbg_regs, width NREGS*XLEN: combinational view of the array, slice 0 tied to 0.
  - Extra output dbg_busy, width NREGS.
  - Both feed the VGA register display.
- Undefined: both ports and their logic are absent; the rest of the port list is unchanged.

Decomposition:
- Shared package pcpu:
  - typedef rf_state_t enum {RF_INIT, RF_READY}.
  - Constants RF_XLEN_DEFAULT=32 and RF_NREGS_DEFAULT=32.
- Sub-module rf_scoreboard (params NREGS, NWR):
  - Owns the busy vector, the reserve/write-clear priority, and the per-port busy lookup.
- regfile_mp owns the array, bypass, read registers and init FSM.

Test Plan:
1. Release rst; hold wr_en=11 to x5 every cycle -> ready=0 for 31 posedges, then 1; reads of x1..x31 return 0; no write took effect.
2. READY: write x5=0xDEADBEEF on port0; next cycle rd_en[0]=1, rd_addr=5 -> rd_data[0]=0xDEADBEEF one edge later.
3. Same cycle: port0 writes x7=0x11, port1 writes x7=0x22; port1 reads x7 -> rd_data[1]=0x22 (bypass), and a later read of x7 returns 0x22.
4. Write x0=0xFFFFFFFF, then read x0 on both ports -> rd_data=0, rd_busy=0.
5. rsv x9 -> rd_busy=1 on the next read. Then write x9 together with rsv x9 -> still 1. Then write x9 alone -> 0.
6. Assert rst mid-INIT at cnt=10, then release -> ready rises 31 edges after release; rd_data and rd_busy are 0 during rst.
